// File: rtl/hd_timing_gen.sv
// Beat and phase timing generator for the HD-CPU hardwired controller.
// Produces one-hot beats W[3:1] and phase pulses T1..T3, halts on STOP, restarts on a QD edge.
module hd_timing_gen #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_qd,
  input  logic       i_short,
  input  logic       i_long,
  input  logic       i_stop,
  output logic       o_t1,
  output logic       o_t2,
  output logic       o_t3,
  output logic [3:1] o_w,
  output logic       o_run
);

  // A single flop cannot resolve metastability, so fewer than two stages is clamped up.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_T3
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [STAGES-1:0] r_sync;
  logic              r_qdPrev;
  logic              w_qdEdge;
  logic              w_beatEnd;
  logic [3:1]        r_beat;
  logic [3:1]        w_nextBeat;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_sync   <= '0;
      r_qdPrev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[STAGES-2:0], i_qd};
      r_qdPrev <= r_sync[STAGES-1];
    end
  end

  assign w_qdEdge = r_sync[STAGES-1] & ~r_qdPrev;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A QD edge only matters while idle; on a running machine it is dropped, not queued.
  always_comb begin
    w_nextState = r_state;
    w_beatEnd   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_qdEdge) begin
          w_nextState = ST_T1;
        end
      end
      ST_T1: w_nextState = ST_T2;
      ST_T2: w_nextState = ST_T3;
      ST_T3: begin
        w_beatEnd   = 1'b1;
        w_nextState = i_stop ? ST_IDLE : ST_T1;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Any encoding other than W1/W2 (including a corrupted one) falls back to W1.
  always_comb begin
    w_nextBeat = 3'b001;
    case (r_beat)
      3'b001:  w_nextBeat = i_short ? 3'b001 : 3'b010;
      3'b010:  w_nextBeat = i_long  ? 3'b100 : 3'b001;
      default: w_nextBeat = 3'b001;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_beat <= 3'b001;
    end else if (w_beatEnd) begin
      r_beat <= w_nextBeat;
    end
  end

  assign o_run = (r_state != ST_IDLE);
  assign o_t1  = (r_state == ST_T1);
  assign o_t2  = (r_state == ST_T2);
  assign o_t3  = (r_state == ST_T3);
  assign o_w   = r_beat;

endmodule

// File: tb/tb_hd_timing_gen.sv
// Self-checking bench for hd_timing_gen: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of beats and phases.
module tb_hd_timing_gen;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       qd = 1'b0;
  logic       shortIn = 1'b0;
  logic       longIn = 1'b0;
  logic       stopIn = 1'b0;
  logic       t1, t2, t3, run;
  logic [3:1] w;
  logic [6:0] obs;

  int checks = 0;
  int passes = 0;

  // Behavioural model: run flag, phase number, beat number and raw QD sample history.
  bit mRun = 1'b0;
  int mPh = 1;
  int mBeat = 1;
  bit qh [0:S];

  hd_timing_gen #(.SYNC_STAGES(S)) dut (
    .i_clk  (clk),
    .i_clr  (clr),
    .i_qd   (qd),
    .i_short(shortIn),
    .i_long (longIn),
    .i_stop (stopIn),
    .o_t1   (t1),
    .o_t2   (t2),
    .o_t3   (t3),
    .o_w    (w),
    .o_run  (run)
  );

  always #5 clk = ~clk;

  assign obs = {run, t1, t2, t3, w};

  task automatic modelStep();
    bit qdEdge;
    if (clr) begin
      mRun  = 1'b0;
      mPh   = 1;
      mBeat = 1;
      for (int i = 0; i <= S; i++) qh[i] = 1'b0;
    end else begin
      qdEdge = qh[S-1] && !qh[S];
      for (int i = S; i > 0; i--) qh[i] = qh[i-1];
      qh[0] = qd;
      if (!mRun) begin
        if (qdEdge) begin
          mRun = 1'b1;
          mPh  = 1;
        end
      end else if (mPh < 3) begin
        mPh = mPh + 1;
      end else begin
        if (mBeat == 1)      mBeat = shortIn ? 1 : 2;
        else if (mBeat == 2) mBeat = longIn ? 3 : 1;
        else                 mBeat = 1;
        if (stopIn) mRun = 1'b0;
        mPh = 1;
      end
    end
  endtask

  function automatic logic [6:0] expVec();
    logic [3:1] wExp;
    wExp = (mBeat == 1) ? 3'b001 : (mBeat == 2) ? 3'b010 : 3'b100;
    return {mRun, mRun && (mPh == 1), mRun && (mPh == 2), mRun && (mPh == 3), wExp};
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic start_from_reset();
    clr = 1'b1; qd = 1'b0; shortIn = 1'b0; longIn = 1'b0; stopIn = 1'b0;
    tick();
    clr = 1'b0;
    qd = 1'b1;
    tick();
    tick();
    qd = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b1; qd = 1'b1; shortIn = 1'b1; longIn = 1'b1; stopIn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 7'b0000001) $display("[TB] FAIL reset_hold cyc%0d: got %b expected %b", i, obs, 7'b0000001);
      else passes++;
    end
    clr = 1'b0; qd = 1'b0; shortIn = 1'b0; longIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== 7'b0000001) $display("[TB] FAIL reset_idle cyc%0d: got %b expected %b", i, obs, 7'b0000001);
      else passes++;
    end
  endtask

  task automatic test_start_short();
    logic [6:0] exp;
    int ph;
    qd = 1'b1; shortIn = 1'b1;
    tick();
    checks++;
    if (obs !== 7'b0000001) $display("[TB] FAIL start_e0: got %b expected %b", obs, 7'b0000001);
    else passes++;
    tick();
    checks++;
    if (obs !== 7'b0000001) $display("[TB] FAIL start_e1: got %b expected %b", obs, 7'b0000001);
    else passes++;
    qd = 1'b0;
    tick();
    checks++;
    if (obs !== 7'b1100001) $display("[TB] FAIL start_e2: got %b expected %b", obs, 7'b1100001);
    else passes++;
    for (int i = 0; i < 12; i++) begin
      tick();
      ph  = ((i + 1) % 3) + 1;
      exp = {1'b1, ph == 1, ph == 2, ph == 3, 3'b001};
      checks++;
      if (obs !== exp) $display("[TB] FAIL short_loop cyc%0d: got %b expected %b", i, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_long_seq();
    logic [3:1] seqLong [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [3:1] seqShort [3] = '{3'b001, 3'b010, 3'b001};
    logic [6:0] exp;
    int ph;
    start_from_reset();
    longIn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      ph  = (i % 3) + 1;
      exp = {1'b1, ph == 1, ph == 2, ph == 3, seqLong[i/3]};
      checks++;
      if (obs !== exp) $display("[TB] FAIL long_seq cyc%0d: got %b expected %b", i, obs, exp);
      else passes++;
    end
    longIn = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      ph  = (i % 3) + 1;
      exp = {1'b1, ph == 1, ph == 2, ph == 3, seqShort[i/3]};
      checks++;
      if (obs !== exp) $display("[TB] FAIL nolong_seq cyc%0d: got %b expected %b", i, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_stop_resume();
    start_from_reset();
    tick();
    tick();
    stopIn = 1'b1;
    tick();
    stopIn = 1'b0;
    checks++;
    if (obs !== 7'b0000010) $display("[TB] FAIL stop_edge: got %b expected %b", obs, 7'b0000010);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      shortIn = 1'($urandom_range(0, 1));
      longIn  = 1'($urandom_range(0, 1));
      stopIn  = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (obs !== 7'b0000010) $display("[TB] FAIL stop_hold cyc%0d: got %b expected %b", i, obs, 7'b0000010);
      else passes++;
    end
    shortIn = 1'b0; longIn = 1'b0; stopIn = 1'b0;
    qd = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 7'b0000010) $display("[TB] FAIL resume_e1: got %b expected %b", obs, 7'b0000010);
    else passes++;
    qd = 1'b0;
    tick();
    checks++;
    if (obs !== 7'b1100010) $display("[TB] FAIL resume_e2: got %b expected %b", obs, 7'b1100010);
    else passes++;
  endtask

  task automatic test_input_timing();
    start_from_reset();
    shortIn = 1'b1;
    tick();
    tick();
    shortIn = 1'b0;
    tick();
    checks++;
    if (obs !== 7'b1100010) $display("[TB] FAIL short_early: got %b expected %b", obs, 7'b1100010);
    else passes++;
    shortIn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (obs !== 7'b1100001) $display("[TB] FAIL short_in_w2: got %b expected %b", obs, 7'b1100001);
    else passes++;
    longIn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (obs !== 7'b1100001) $display("[TB] FAIL short_over_long: got %b expected %b", obs, 7'b1100001);
    else passes++;
    longIn = 1'b0;
    qd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) qd = 1'b0;
      tick();
      checks++;
      if (obs !== expVec()) $display("[TB] FAIL qd_while_run cyc%0d: got %b expected %b", i, obs, expVec());
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    start_from_reset();
    longIn = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (obs !== 7'b1010100) $display("[TB] FAIL w3_t2: got %b expected %b", obs, 7'b1010100);
    else passes++;
    clr = 1'b1;
    tick();
    checks++;
    if (obs !== 7'b0000001) $display("[TB] FAIL mid_reset: got %b expected %b", obs, 7'b0000001);
    else passes++;
    clr = 1'b0; longIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== 7'b0000001) $display("[TB] FAIL post_reset cyc%0d: got %b expected %b", i, obs, 7'b0000001);
      else passes++;
    end
  endtask

  task automatic test_random();
    int qdHold = 0;
    for (int i = 0; i < 800; i++) begin
      clr     = ($urandom_range(0, 149) == 0);
      shortIn = 1'($urandom_range(0, 1));
      longIn  = 1'($urandom_range(0, 1));
      stopIn  = ($urandom_range(0, 5) == 0);
      if (qdHold == 0) begin
        qd     = ~qd;
        qdHold = $urandom_range(2, 7);
      end
      qdHold--;
      tick();
      checks++;
      if (obs !== expVec()) $display("[TB] FAIL random cyc%0d: got %b expected %b", i, obs, expVec());
      else passes++;
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_short();
    test_long_seq();
    test_stop_resume();
    test_input_timing();
    test_mid_reset();
    test_random();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
